// File: rtl/regfile_sb_mod.sv
// regfile_sb_mod: parametrised register file with N read ports, optional
// write-to-read bypass, optional hard-wired zero register, a per-register
// busy scoreboard and a hardware clear sequencer run after reset or on request.
module regfile_sb_mod #(
    parameter int DATA_W   = 34,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
    output logic [NUM_RD*DATA_W-1:0] rdata_o,
    output logic [NUM_RD-1:0]        busy_o,
    input  logic                     wen_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     rsv_en_i,
    input  logic [ADDR_W-1:0]        rsv_addr_i,
    input  logic                     clear_i,
    output logic                     ready_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cnt, cnt_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    busy_q;
    logic                run, wr_ok, rsv_ok;

    assign run     = (state == RUN);
    assign ready_o = run;

    // A clear request in RUN drops the write and reserve of the same cycle,
    // so neither may reach storage or the bypass path.
    assign wr_ok  = run && !clear_i && wen_i &&
                    !((ZERO_REG != 0) && (waddr_i == '0));
    assign rsv_ok = run && !clear_i && rsv_en_i &&
                    !((ZERO_REG != 0) && (rsv_addr_i == '0));

    // State and clear counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: walk every address once in CLEAR, restart on clear_i.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == ADDR_W'(DEPTH - 1)) state_nxt = RUN;
            end
            RUN: begin
                if (clear_i) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Busy scoreboard: write retires a producer, a reservation (newer) wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else if (!run || clear_i) begin
            busy_q <= '0;
        end else begin
            if (wr_ok)  busy_q[waddr_i]    <= 1'b0;
            if (rsv_ok) busy_q[rsv_addr_i] <= 1'b1;
        end
    end

    // Register array: zeroed one entry per edge in CLEAR, written in RUN.
    // No reset here; contents are defined only once the clear completes.
    always_ff @(posedge clk) begin
        if (!run)       mem[cnt]     <= '0;
        else if (wr_ok) mem[waddr_i] <= wdata_i;
    end

    // Combinational read ports with optional forwarding of this cycle's
    // write data and reservation.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              zhit, whit, rhit;

        assign ra   = raddr_i[k*ADDR_W +: ADDR_W];
        assign zhit = (ZERO_REG != 0) && (ra == '0);
        assign whit = (BYPASS != 0) && wr_ok  && (waddr_i    == ra);
        assign rhit = (BYPASS != 0) && rsv_ok && (rsv_addr_i == ra);

        assign rdata_o[k*DATA_W +: DATA_W] = (!run || zhit) ? '0 :
                                             whit ? wdata_i : mem[ra];
        assign busy_o[k] = (!run || zhit) ? 1'b0 :
                           (rhit || (!whit && busy_q[ra]));
    end
endmodule

// File: tb/tb_regfile_sb_mod.sv
// Bench for regfile_sb_mod at default parameters (BYPASS=1, ZERO_REG=1).
module tb_regfile_sb_mod;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  raddr_i;
    logic [67:0] rdata_o;
    logic [1:0]  busy_o;
    logic        wen_i;
    logic [4:0]  waddr_i;
    logic [33:0] wdata_i;
    logic        rsv_en_i;
    logic [4:0]  rsv_addr_i;
    logic        clear_i;
    logic        ready_o;

    int total = 0;
    int bad   = 0;

    regfile_sb_mod dut (
        .clk(clk), .rst_n(rst_n), .raddr_i(raddr_i), .rdata_o(rdata_o),
        .busy_o(busy_o), .wen_i(wen_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .rsv_en_i(rsv_en_i), .rsv_addr_i(rsv_addr_i), .clear_i(clear_i),
        .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [33:0] wdata;
        logic        rsv;
        logic [4:0]  raddr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [33:0] e0;
        logic [33:0] e1;
        logic [1:0]  eb;
    } vec_t;

    typedef struct {
        string       name;
        logic [67:0] rdata;
        logic [1:0]  busy;
    } exp_t;

    exp_t sb[$];
    vec_t vt[13];

    function automatic logic [33:0] fv(int i);
        return 34'h2_0000_0000 | 34'(i * 32'h0001_1111);
    endfunction

    task automatic push(string name, logic [33:0] e0, logic [33:0] e1, logic [1:0] eb);
        exp_t e;
        e.name  = name;
        e.rdata = {e1, e0};
        e.busy  = eb;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_empty: no expected entry for DUT output");
        end else begin
            e = sb.pop_front();
            if (rdata_o !== e.rdata || busy_o !== e.busy) begin
                bad++;
                $display("FAIL %s: rdata=%h busy=%b expected rdata=%h busy=%b",
                         e.name, rdata_o, busy_o, e.rdata, e.busy);
            end
        end
    endtask

    task automatic chk_ready(string name, logic exp);
        total++;
        if (ready_o !== exp) begin
            bad++;
            $display("FAIL %s: ready=%b expected %b", name, ready_o, exp);
        end
    endtask

    task automatic idle();
        wen_i = 0; waddr_i = 0; wdata_i = 0; rsv_en_i = 0; rsv_addr_i = 0; clear_i = 0;
    endtask

    // Count edges after a clear start: ready low through edge 31, high at 32.
    task automatic count_clear(string name);
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk); #1;
            chk_ready($sformatf("%s_edge%0d", name, i), i == 32);
        end
    endtask

    task automatic read_all(string name, bit use_fill, logic [31:0] bmask);
        for (int i = 0; i < 32; i += 2) begin
            @(negedge clk);
            raddr_i = {5'(i + 1), 5'(i)};
            push($sformatf("%s_r%0d", name, i),
                 (use_fill && i != 0) ? fv(i) : 34'h0,
                 use_fill ? fv(i + 1) : 34'h0,
                 {bmask[i + 1], bmask[i]});
            #2 pop_check();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //        wen waddr wdata           rsv raddr ra0 ra1 e0              e1              eb
        vt[0]  = '{1, 5,  34'h3_FFFF_FFFF, 0, 0,  5, 5, 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 2'b00};
        vt[1]  = '{0, 0,  34'h0,           0, 0,  5, 0, 34'h3_FFFF_FFFF, 34'h0,           2'b00};
        vt[2]  = '{0, 0,  34'h0,           1, 7,  7, 5, 34'h0,           34'h3_FFFF_FFFF, 2'b01};
        vt[3]  = '{0, 0,  34'h0,           0, 0,  7, 7, 34'h0,           34'h0,           2'b11};
        vt[4]  = '{0, 0,  34'h0,           0, 0,  7, 7, 34'h0,           34'h0,           2'b11};
        vt[5]  = '{0, 0,  34'h0,           0, 0,  7, 5, 34'h0,           34'h3_FFFF_FFFF, 2'b01};
        vt[6]  = '{1, 7,  34'h12,          0, 0,  7, 7, 34'h12,          34'h12,          2'b00};
        vt[7]  = '{0, 0,  34'h0,           0, 0,  7, 7, 34'h12,          34'h12,          2'b00};
        vt[8]  = '{1, 9,  34'h55,          1, 9,  9, 9, 34'h55,          34'h55,          2'b11};
        vt[9]  = '{0, 0,  34'h0,           0, 0,  9, 7, 34'h55,          34'h12,          2'b01};
        vt[10] = '{1, 0,  34'hAA,          1, 0,  0, 0, 34'h0,           34'h0,           2'b00};
        vt[11] = '{0, 0,  34'h0,           0, 0,  0, 9, 34'h0,           34'h55,          2'b10};
        vt[12] = '{1, 3,  34'h33,          0, 0,  3, 5, 34'h33,          34'h3_FFFF_FFFF, 2'b00};

        idle();
        raddr_i = 0;
        rst_n   = 0;
        #23;
        push("reset_outputs", 34'h0, 34'h0, 2'b00);
        pop_check();
        chk_ready("reset_ready", 1'b0);
        @(negedge clk);
        rst_n = 1;
        count_clear("init");
        read_all("init_zero", 0, 32'h0);

        // Table: drive one cycle, check same-cycle outputs, then the edge commits.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            wen_i = vt[i].wen; waddr_i = vt[i].waddr; wdata_i = vt[i].wdata;
            rsv_en_i = vt[i].rsv; rsv_addr_i = vt[i].raddr;
            raddr_i = {vt[i].ra1, vt[i].ra0};
            push($sformatf("vec%0d", i), vt[i].e0, vt[i].e1, vt[i].eb);
            #2 pop_check();
        end

        // Fill r1..r31, reserve r4 and r8, then check contents and busy map.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            idle();
            wen_i = 1; waddr_i = 5'(i); wdata_i = fv(i);
        end
        @(negedge clk);
        idle(); rsv_en_i = 1; rsv_addr_i = 4;
        @(negedge clk);
        rsv_en_i = 1; rsv_addr_i = 8;
        @(negedge clk);
        idle();
        read_all("fill", 1, 32'h0000_0110);

        // Clear pulse with a concurrent write to r3 and reserve of r11.
        @(negedge clk);
        clear_i = 1; wen_i = 1; waddr_i = 3; wdata_i = 34'h777;
        rsv_en_i = 1; rsv_addr_i = 11;
        raddr_i = {5'd11, 5'd3};
        push("clear_pulse_cycle", fv(3), fv(11), 2'b00);
        #2 pop_check();
        @(negedge clk);
        idle();
        raddr_i = {5'd8, 5'd3};
        push("during_clear", 34'h0, 34'h0, 2'b00);
        #2 pop_check();
        count_clear("clr");
        read_all("after_clear", 0, 32'h0);

        // Reset asserted with the clear counter at 10.
        @(negedge clk);
        clear_i = 1;
        @(negedge clk);
        clear_i = 0;
        repeat (10) @(posedge clk);
        #2 rst_n = 0;
        #1 chk_ready("midclear_reset", 1'b0);
        @(negedge clk);
        rst_n = 1;
        count_clear("rst10");

        // Reset mid-run takes effect immediately.
        @(negedge clk);
        rsv_en_i = 1; rsv_addr_i = 6;
        @(negedge clk);
        idle();
        raddr_i = {5'd5, 5'd6};
        push("run_busy_r6", 34'h0, 34'h0, 2'b01);
        #1 pop_check();
        rst_n = 0;
        #1;
        push("midrun_reset", 34'h0, 34'h0, 2'b00);
        pop_check();
        chk_ready("midrun_ready", 1'b0);
        @(negedge clk);
        rst_n = 1;
        count_clear("rst_run");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
